// File: rtl/pdm_pkg.sv
// Shared constants and helpers for the PDM microphone path.
// Holds default parameters, the ones-counter width helper and a saturator.
package pdm_pkg;

  localparam int DEF_DATA_WIDTH      = 16;
  localparam int DEF_CLK_HALF_PERIOD = 25;
  localparam int DEF_DECIM_RATE      = 45;
  localparam int DEF_GAIN_SHIFT      = 9;

  // Raw decimated value spans +/-255 at most, 11 bits signed covers 2*255.
  localparam int RAW_W = 11;
  localparam int SAT_W = 64;

  function automatic int ones_w(input int decim);
    return $clog2(decim + 1);
  endfunction

  function automatic logic signed [SAT_W-1:0] sat(
    input logic signed [SAT_W-1:0] v,
    input int                      dw
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// PDM clock divider: mic_clk from HCLK plus a sample strobe on the last
// HCLK cycle of each high phase. Ports: HCLK, HRESET, i_enable, o_mic_clk, o_sample_evt.
module pdm_clk_gen
  import pdm_pkg::*;
#(
  parameter int CLK_HALF_PERIOD = DEF_CLK_HALF_PERIOD
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic i_enable,
  output logic o_mic_clk,
  output logic o_sample_evt
);

  localparam int DW = $clog2(CLK_HALF_PERIOD);

  logic [DW-1:0] r_div;
  logic          r_clk;
  logic          w_tc;

  assign w_tc = (r_div == DW'(CLK_HALF_PERIOD - 1));

  always_ff @(posedge HCLK) begin
    if (HRESET || !i_enable) begin
      r_div <= '0;
      r_clk <= 1'b0;
    end else if (w_tc) begin
      r_div <= '0;
      r_clk <= ~r_clk;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  assign o_mic_clk    = r_clk;
  // Data is valid while mic_clk is high; sample at the end of that phase.
  assign o_sample_evt = i_enable && w_tc && r_clk;

endmodule

// File: rtl/pdm_deserializer.sv
// PDM receive path: synchronize mic_data, count ones per window, scale,
// saturate and present signed PCM on a valid/ready port with overrun flag.
module pdm_deserializer
  import pdm_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int CLK_HALF_PERIOD = DEF_CLK_HALF_PERIOD,
  parameter int DECIM_RATE      = DEF_DECIM_RATE,
  parameter int GAIN_SHIFT      = DEF_GAIN_SHIFT
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  enable,
  input  logic                  mic_data,
  output logic                  mic_clk,
  output logic                  mic_lrsel,
  output logic [DATA_WIDTH-1:0] pcm_data,
  output logic                  pcm_valid,
  input  logic                  pcm_ready,
  output logic                  overrun
);

  localparam int CW = ones_w(DECIM_RATE);

  logic                    r_sync1;
  logic                    r_sync2;
  logic                    w_evt;
  logic                    w_last;
  logic [CW-1:0]           r_ones;
  logic [7:0]              r_bits;
  logic [8:0]              w_ones_tot;
  logic signed [RAW_W-1:0] w_raw;
  logic signed [SAT_W-1:0] w_scaled;
  logic [DATA_WIDTH-1:0]   w_pcm;

  pdm_clk_gen #(
    .CLK_HALF_PERIOD(CLK_HALF_PERIOD)
  ) u_clk_gen (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .i_enable    (enable),
    .o_mic_clk   (mic_clk),
    .o_sample_evt(w_evt)
  );

  assign mic_lrsel = 1'b0;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= mic_data;
      r_sync2 <= r_sync1;
    end
  end

  assign w_last = w_evt && (r_bits == 8'(DECIM_RATE - 1));

  // Final bit is folded in combinationally so the window closes on its event.
  assign w_ones_tot = 9'(r_ones) + 9'(r_sync2);
  assign w_raw      = $signed({1'b0, w_ones_tot, 1'b0})
                    - $signed(RAW_W'(DECIM_RATE));
  assign w_scaled   = SAT_W'(w_raw) <<< GAIN_SHIFT;
  assign w_pcm      = DATA_WIDTH'(sat(w_scaled, DATA_WIDTH));

  always_ff @(posedge HCLK) begin
    if (HRESET || !enable) begin
      r_ones <= '0;
      r_bits <= '0;
    end else if (w_last) begin
      r_ones <= '0;
      r_bits <= '0;
    end else if (w_evt) begin
      r_ones <= r_ones + CW'(r_sync2);
      r_bits <= r_bits + 8'd1;
    end
  end

  // Output register is independent of enable: a pending sample waits.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pcm_data  <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= w_last && pcm_valid && !pcm_ready;
      if (w_last) begin
        pcm_data  <= w_pcm;
        pcm_valid <= 1'b1;
      end else if (pcm_valid && pcm_ready) begin
        pcm_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdm_deserializer.sv
// Bench for pdm_deserializer: two DUTs (gain 9 and 10) on shared stimulus,
// checked each cycle against a window-level model plus literal checks.
module tb_pdm_deserializer;

  localparam int H   = 3;
  localparam int D   = 45;
  localparam int DW  = 16;
  localparam int PER = 2 * H * D;

  logic HCLK      = 1'b0;
  logic HRESET    = 1'b1;
  logic enable    = 1'b1;
  logic mic_data  = 1'b0;
  logic pcm_ready = 1'b1;

  logic          mclk_a, lr_a, val_a, ovr_a;
  logic [DW-1:0] pcm_a;
  logic          mclk_b, lr_b, val_b, ovr_b;
  logic [DW-1:0] pcm_b;

  int n_cmp = 0;
  int n_err = 0;
  int mode  = 0;

  always #5 HCLK = ~HCLK;

  pdm_deserializer #(
    .DATA_WIDTH(DW), .CLK_HALF_PERIOD(H),
    .DECIM_RATE(D), .GAIN_SHIFT(9)
  ) dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .enable(enable),
    .mic_data(mic_data), .mic_clk(mclk_a), .mic_lrsel(lr_a),
    .pcm_data(pcm_a), .pcm_valid(val_a),
    .pcm_ready(pcm_ready), .overrun(ovr_a)
  );

  pdm_deserializer #(
    .DATA_WIDTH(DW), .CLK_HALF_PERIOD(H),
    .DECIM_RATE(D), .GAIN_SHIFT(10)
  ) dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .enable(enable),
    .mic_data(mic_data), .mic_clk(mclk_b), .mic_lrsel(lr_b),
    .pcm_data(pcm_b), .pcm_valid(val_b),
    .pcm_ready(pcm_ready), .overrun(ovr_b)
  );

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic longint pcm_of(input int ones, input int gs);
    longint v;
    v = longint'(2 * ones - D) * (longint'(1) << gs);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  // Model: k counts enabled cycles; every 2H-th one samples a bit that
  // entered mic_data two edges earlier; D bits close a window.
  int     k = 0;
  bit     win[$];
  bit     hist[$];
  bit     live = 1'b0;
  bit     e_val = 1'b0, e_ovr = 1'b0, e_mclk = 1'b0;
  longint e_a = 0, e_b = 0;

  always @(posedge HCLK) begin
    bit sy;
    int ones;
    live = 1'b1;
    if (HRESET) begin
      k = 0;
      win.delete();
      hist.delete();
      hist.push_back(1'b0);
      e_val = 0; e_ovr = 0; e_mclk = 0; e_a = 0; e_b = 0;
    end else begin
      sy = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
      hist.push_back(mic_data);
      if (hist.size() > 4) void'(hist.pop_front());
      e_ovr = 1'b0;
      if (!enable) begin
        k = 0;
        win.delete();
        e_mclk = 1'b0;
        if (e_val && pcm_ready) e_val = 1'b0;
      end else begin
        if (k % (2 * H) == 2 * H - 1) win.push_back(sy);
        if (win.size() == D) begin
          ones = 0;
          foreach (win[i]) ones += int'(win[i]);
          e_ovr = e_val && !pcm_ready;
          e_val = 1'b1;
          e_a   = pcm_of(ones, 9);
          e_b   = pcm_of(ones, 10);
          win.delete();
        end else if (e_val && pcm_ready) begin
          e_val = 1'b0;
        end
        k++;
        e_mclk = ((k / H) % 2) == 1;
      end
    end
  end

  always @(negedge HCLK) begin
    if (live) begin
      chk("mic_clk_a", longint'(mclk_a), longint'(e_mclk));
      chk("mic_clk_b", longint'(mclk_b), longint'(e_mclk));
      chk("lrsel_a", longint'(lr_a), 0);
      chk("valid_a", longint'(val_a), longint'(e_val));
      chk("valid_b", longint'(val_b), longint'(e_val));
      chk("overrun_a", longint'(ovr_a), longint'(e_ovr));
      chk("overrun_b", longint'(ovr_b), longint'(e_ovr));
      chk("data_a", longint'($signed(pcm_a)), e_a);
      chk("data_b", longint'($signed(pcm_b)), e_b);
    end
  end

  // Stream source: new bits change just after mic_clk falls.
  always @(negedge mclk_a) begin
    #1;
    case (mode)
      2: mic_data = ~mic_data;
      3: mic_data = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  task automatic step(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic wait_valid(input string nm, output int n);
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!val_a && n < 2 * PER);
    if (!val_a) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no pcm_valid within %0d cycles", nm, 2 * PER);
    end
  endtask

  task automatic do_reset(input int m, input logic md);
    HRESET = 1'b1;
    step(2);
    mode     = m;
    mic_data = md;
    step(2);
    HRESET = 1'b0;
  endtask

  initial begin
    int n;
    int n_ovr;

    step(3);
    chk("rst_valid", longint'(val_a), 0);
    chk("rst_data", longint'(pcm_a), 0);
    chk("rst_mclk", longint'(mclk_a), 0);
    chk("rst_ovr", longint'(ovr_a), 0);

    // All ones
    do_reset(1, 1'b1);
    wait_valid("ones_first", n);
    chk("first_latency", n, PER);
    chk("ones_a", longint'($signed(pcm_a)), 23040);
    chk("ones_sat_b", longint'($signed(pcm_b)), 32767);
    wait_valid("ones_second", n);
    chk("sample_period", n, PER);

    // All zeros
    do_reset(0, 1'b0);
    wait_valid("zeros", n);
    chk("zeros_a", longint'($signed(pcm_a)), -23040);
    chk("zeros_sat_b", longint'($signed(pcm_b)), -32768);

    // Alternating, starting with 1
    do_reset(2, 1'b1);
    wait_valid("alt", n);
    chk("alt_a", longint'($signed(pcm_a)), 512);
    chk("alt_b", longint'($signed(pcm_b)), 1024);
    wait_valid("alt2", n);

    // Random data, random ready, rare enable drops
    mode = 3;
    for (int i = 0; i < 20 * PER; i++) begin
      pcm_ready = 1'($urandom_range(0, 1));
      enable    = ($urandom_range(0, 199) != 0);
      step(1);
    end
    enable    = 1'b1;
    pcm_ready = 1'b1;

    // Backpressure
    pcm_ready = 1'b0;
    do_reset(1, 1'b1);
    wait_valid("bp_first", n);
    n_ovr = 0;
    for (int i = 0; i < PER; i++) begin
      step(1);
      if (ovr_a) n_ovr++;
    end
    chk("bp_ovr_count", n_ovr, 1);
    chk("bp_ovr_last", longint'(ovr_a), 1);
    chk("bp_data", longint'($signed(pcm_a)), 23040);
    pcm_ready = 1'b1;
    step(1);
    chk("bp_drop", longint'(val_a), 0);
    pcm_ready = 1'b0;

    // Handshake on the completion cycle
    mode     = 0;
    mic_data = 1'b0;
    wait_valid("same_pend", n);
    step(PER - 1);
    pcm_ready = 1'b1;
    step(1);
    chk("same_valid", longint'(val_a), 1);
    chk("same_ovr", longint'(ovr_a), 0);
    step(1);
    chk("same_drop", longint'(val_a), 0);

    // Enable low after 20 bits, resume with zeros
    do_reset(1, 1'b1);
    step(20 * 2 * H + 3);
    chk("en_mclk_high", longint'(mclk_a), 1);
    enable = 1'b0;
    step(1);
    chk("en_mclk_low", longint'(mclk_a), 0);
    mode     = 0;
    mic_data = 1'b0;
    step(10);
    enable = 1'b1;
    wait_valid("en_resume", n);
    chk("en_latency", n, PER);
    chk("en_fresh", longint'($signed(pcm_a)), -23040);

    // Reset mid-window with a pending sample
    pcm_ready = 1'b0;
    mode      = 1;
    mic_data  = 1'b1;
    wait_valid("rst_pend", n);
    step(100);
    chk("rst_pending", longint'(val_a), 1);
    HRESET = 1'b1;
    step(1);
    chk("rst_mid_valid", longint'(val_a), 0);
    chk("rst_mid_data", longint'(pcm_a), 0);
    chk("rst_mid_mclk", longint'(mclk_a), 0);
    chk("rst_mid_ovr", longint'(ovr_a), 0);
    HRESET = 1'b0;
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
